// File: rtl/reg_bank.sv
// Bank of 2^ADDR_W registers with a single load/inc/dec/clear write port, two registered read ports and flags.
// Optional macro REG_BANK_BYPASS_EN forwards the value being written to a read port on the same address.
module reg_bank #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              R_W,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] WA,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic              Ea,
  output logic [WIDTH-1:0]  Q,
  output logic [WIDTH-1:0]  Qa,
  output logic              Z,
  output logic              C
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [WIDTH-1:0] bank_d [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] qa_q, qa_d;
  logic             z_q, z_d;
  logic             c_q, c_d;

  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] wr_val;
  logic             wr_carry;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // Result of the write-port operation on the currently addressed register
  always_comb begin
    cur_val  = bank_q[WA];
    wr_val   = cur_val;
    wr_carry = 1'b0;
    case (OP)
      2'b00: wr_val = D;
      2'b01: begin
        wr_val   = cur_val + ONE;
        wr_carry = (cur_val == ONES);
      end
      2'b10: begin
        wr_val   = cur_val - ONE;
        wr_carry = (cur_val == ZERO);
      end
      2'b11: wr_val = ZERO;
      default: begin
        wr_val   = ZERO;
        wr_carry = 1'b0;
      end
    endcase
  end

  // Next state of bank, flags and read ports
  always_comb begin
    bank_d = bank_q;
    z_d    = z_q;
    c_d    = c_q;
    if (R_W) begin
      bank_d[WA] = wr_val;
      z_d        = (wr_val == ZERO);
      c_d        = wr_carry;
    end else begin
      z_d = z_q;
      c_d = c_q;
    end

`ifdef REG_BANK_BYPASS_EN
    // Forward r' to a port reading the register being written this cycle
    if (R_W && (RA == WA)) begin
      rd_a = wr_val;
    end else begin
      rd_a = bank_q[RA];
    end
    if (R_W && (RB == WA)) begin
      rd_b = wr_val;
    end else begin
      rd_b = bank_q[RB];
    end
`else
    rd_a = bank_q[RA];
    rd_b = bank_q[RB];
`endif

    q_d = rd_a;
    if (Ea) begin
      qa_d = rd_b;
    end else begin
      qa_d = qa_q;
    end
  end

  // State registers; CLR clears everything asynchronously
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      bank_q <= '{default: ZERO};
      q_q    <= ZERO;
      qa_q   <= ZERO;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
    end else begin
      bank_q <= bank_d;
      q_q    <= q_d;
      qa_q   <= qa_d;
      z_q    <= z_d;
      c_q    <= c_d;
    end
  end

  assign Q  = q_q;
  assign Qa = qa_q;
  assign Z  = z_q;
  assign C  = c_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: vector table, directed corner cases, and randomized run against an arithmetic model.
module tb_reg_bank;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        R_W = 1'b0;
  logic [1:0]  OP  = 2'b00;
  logic [2:0]  WA  = 3'd0;
  logic [15:0] D   = 16'h0000;
  logic [2:0]  RA  = 3'd0;
  logic [2:0]  RB  = 3'd0;
  logic        Ea  = 1'b0;
  logic [15:0] Q, Qa;
  logic        Z, C;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef REG_BANK_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  reg_bank #(.WIDTH(16), .ADDR_W(3)) dut (
    .CLK(CLK), .CLR(CLR), .R_W(R_W), .OP(OP), .WA(WA), .D(D),
    .RA(RA), .RB(RB), .Ea(Ea), .Q(Q), .Qa(Qa), .Z(Z), .C(C)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain integers, modulo 2^16 arithmetic
  int mbank [8];
  int mq, mqa;
  bit mz, mc;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mbank[i] = 0;
    mq = 0; mqa = 0; mz = 1'b0; mc = 1'b0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance model, return 1ns after posedge
  task automatic step(input bit rw, input int op, input int wa, input int d,
                      input int ra, input int rb, input bit ea);
    int oldv, newv, nq, nqa;
    bit carry;
    @(negedge CLK);
    R_W = rw; OP = op[1:0]; WA = wa[2:0]; D = d[15:0];
    RA = ra[2:0]; RB = rb[2:0]; Ea = ea;
    oldv = mbank[wa];
    carry = 1'b0;
    case (op)
      0: newv = d & 16'hFFFF;
      1: begin newv = (oldv + 1) % 65536; carry = (oldv == 65535); end
      2: begin newv = (oldv + 65535) % 65536; carry = (oldv == 0); end
      default: newv = 0;
    endcase
    nq  = (BYPASS && rw && ra == wa) ? newv : mbank[ra];
    nqa = (BYPASS && rw && rb == wa) ? newv : mbank[rb];
    @(posedge CLK);
    if (rw) begin
      mbank[wa] = newv;
      mz = (newv == 0);
      mc = carry;
    end
    mq = nq;
    if (ea) mqa = nqa;
    #1;
  endtask

  typedef struct {
    bit rw; int op; int wa; int d; int ra; int rb; bit ea;
    int eq; int eqa; bit ez; bit ec;
  } vec_t;
  vec_t tbl [12];

  initial begin
    // Power-on reset state
    #12;
    chk("reset_Q", Q, 16'h0000);
    chk("reset_Qa", Qa, 16'h0000);
    chk("reset_Z", Z, 1'b0);
    chk("reset_C", C, 1'b0);
    CLR = 1'b0;
    model_reset();

    tbl[0]  = '{1, 0, 5, 'h1234, 0, 0, 1, 'h0000, 'h0000, 0, 0};
    tbl[1]  = '{0, 0, 0, 'h0000, 5, 5, 1, 'h1234, 'h1234, 0, 0};
    tbl[2]  = '{1, 0, 1, 'hFFFF, 5, 0, 0, 'h1234, 'h1234, 0, 0};
    tbl[3]  = '{1, 1, 1, 'h0000, 5, 5, 1, 'h1234, 'h1234, 1, 1};
    tbl[4]  = '{0, 0, 0, 'h0000, 1, 1, 1, 'h0000, 'h0000, 1, 1};
    tbl[5]  = '{1, 2, 1, 'h0000, 5, 2, 1, 'h1234, 'h0000, 0, 1};
    tbl[6]  = '{0, 0, 0, 'h0000, 1, 5, 0, 'hFFFF, 'h0000, 0, 1};
    tbl[7]  = '{1, 2, 1, 'h0000, 0, 5, 1, 'h0000, 'h1234, 0, 0};
    tbl[8]  = '{1, 3, 5, 'h0000, 1, 1, 1, 'hFFFE, 'hFFFE, 1, 0};
    tbl[9]  = '{0, 0, 0, 'h0000, 5, 5, 1, 'h0000, 'h0000, 1, 0};
    tbl[10] = '{1, 1, 3, 'h0000, 2, 2, 1, 'h0000, 'h0000, 0, 0};
    tbl[11] = '{1, 0, 3, 'h0000, 1, 0, 0, 'hFFFE, 'h0000, 1, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rw, tbl[i].op, tbl[i].wa, tbl[i].d, tbl[i].ra, tbl[i].rb, tbl[i].ea);
      chk($sformatf("vec%0d_Q", i), Q, tbl[i].eq);
      chk($sformatf("vec%0d_Qa", i), Qa, tbl[i].eqa);
      chk($sformatf("vec%0d_Z", i), Z, tbl[i].ez);
      chk($sformatf("vec%0d_C", i), C, tbl[i].ec);
    end

    // Asynchronous reset between edges
    step(1, 0, 2, 'hBEEF, 0, 0, 0);
    step(0, 0, 0, 0, 2, 2, 1);
    chk("pre_clr_Q", Q, 16'hBEEF);
    #2 CLR = 1'b1;
    #1;
    model_reset();
    chk("async_clr_Q", Q, 16'h0000);
    chk("async_clr_Qa", Qa, 16'h0000);
    chk("async_clr_Z", Z, 1'b0);
    chk("async_clr_C", C, 1'b0);
    CLR = 1'b0;
    step(0, 0, 0, 0, 2, 2, 1);
    chk("after_clr_reg2", Q, 16'h0000);

    // Ea gating
    step(1, 0, 3, 'h00AA, 0, 0, 0);
    step(0, 0, 0, 0, 0, 3, 1);
    chk("ea_load_Qa", Qa, 16'h00AA);
    step(1, 0, 3, 'h0055, 0, 3, 0);
    chk("ea_hold1_Qa", Qa, 16'h00AA);
    step(0, 0, 0, 0, 0, 3, 0);
    chk("ea_hold2_Qa", Qa, 16'h00AA);
    step(0, 0, 0, 0, 0, 3, 1);
    chk("ea_open_Qa", Qa, 16'h0055);

    // Read during write
    step(1, 0, 4, 'h1111, 0, 0, 0);
    step(1, 0, 4, 'h0F0F, 4, 0, 0);
    chk("rdw_Q", Q, BYPASS ? 16'h0F0F : 16'h1111);
    step(0, 0, 0, 0, 4, 0, 0);
    chk("rdw_next_Q", Q, 16'h0F0F);

    // Isolation: write all, clear reg 6
    for (int i = 0; i < 8; i++) step(1, 0, i, 'h1000 + i * 'h0101, 0, 0, 0);
    step(1, 3, 6, 0, 0, 0, 0);
    chk("iso_Z", Z, 1'b1);
    chk("iso_C", C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, i, 7 - i, 1);
      chk($sformatf("iso_Q%0d", i), Q, (i == 6) ? 0 : 'h1000 + i * 'h0101);
      chk($sformatf("iso_Qa%0d", 7 - i), Qa, (7 - i == 6) ? 0 : 'h1000 + (7 - i) * 'h0101);
    end

    // Randomized run against the model, with occasional async reset pulses
    for (int n = 0; n < 400; n++) begin
      int wa, ra, rb, op, d;
      bit rw, ea;
      rw = ($urandom_range(0, 3) != 0);
      op = $urandom_range(0, 3);
      wa = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      rb = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      ea = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: d = 16'hFFFF;
        1: d = 16'h0000;
        default: d = $urandom_range(0, 65535);
      endcase
      step(rw, op, wa, d, ra, rb, ea);
      chk("rnd_Q", Q, mq);
      chk("rnd_Qa", Qa, mqa);
      chk("rnd_Z", Z, mz);
      chk("rnd_C", C, mc);
      if ($urandom_range(0, 49) == 0) begin
        #2 CLR = 1'b1;
        #1;
        model_reset();
        chk("rnd_clr_Q", Q, 0);
        chk("rnd_clr_Qa", Qa, 0);
        CLR = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-register bank that replaces the single 16-bit register in the ALU datapath. It holds 2^ADDR_W words of WIDTH bits, performs one write-port operation per cycle (load, increment, decrement, clear), and provides two registered read ports. Port A is the free-running operand port. Port B is the enable-gated accumulator port. Registered zero and carry flags report the result of the last write for the ALU control logic.

## Interface
Parameters:
- WIDTH, 16, word width in bits (≥2)
- ADDR_W, 3, address width; bank holds 2^ADDR_W registers

Ports:
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  asynchronous reset, active-high
- R_W  in  1  1 = write cycle (operation OP applied to register WA); 0 = no write
- OP  in  2  write operation: 00 load D, 01 increment, 10 decrement, 11 clear
- WA  in  ADDR_W  write address
- D  in  WIDTH  write data (used only by OP=00)
- RA  in  ADDR_W  read address, port Q
- RB  in  ADDR_W  read address, port Qa
- Ea  in  1  1 = Qa updates this cycle; 0 = Qa holds
- Q  out  WIDTH  registered read of RA
- Qa  out  WIDTH  registered read of RB, gated by Ea
- Z  out  1  registered: result of last write was zero
- C  out  1  registered: last increment/decrement wrapped

## Operation
- Reset (CLR=1, asynchronous): every bank register, Q, Qa, Z and C are cleared to 0 immediately. CLR has priority over every other input. All inputs are ignored while CLR is high.
- Write, when R_W=1. Register WA takes its next value r' at the rising edge:
  - OP=00: r' = D
  - OP=01: r' = r+1 mod 2^WIDTH
  - OP=10: r' = r−1 mod 2^WIDTH
  - OP=11: r' = 0
- Flags, on a write cycle only:
  - Z ← (r' == 0)
  - C ← 1 only on increment from all-ones or decrement from 0; C ← 0 otherwise
- Flags hold when R_W=0.
- Only register WA changes on a write. Every other register holds.
- Q ← bank[RA] on every edge.
- Qa ← bank[RB] on edges where Ea=1. Qa holds when Ea=0.
- Read-during-write to the same address: the read port returns the pre-write value. With REG_BANK_BYPASS_EN, it returns r' instead (see Configuration).
- RA and RB may be equal. Both ports then return the same value.
- No illegal encodings exist. All OP and address values are valid.

## Timing
- Write latency: 1 cycle. r' is visible in the bank after the edge where R_W=1.
- Read latency: 1 cycle. Q and Qa show the addressed value after the edge following address presentation.
- Write followed by a read of the same address: the write at edge n is returned on Q after edge n+1 without bypass, and after edge n without bypass... with REG_BANK_BYPASS_EN.
- Flags are valid after the same edge as the write and stay stable until the next write.
- Back-to-back writes to one register chain correctly. For example, two consecutive OP=01 cycles on a register add 2.
- Reset mid-operation: a CLR pulse of any length, asynchronous to CLK, clears all state. The first edge with CLR low acts on the inputs normally.

## Configuration
- REG_BANK_BYPASS_EN defined: write-to-read forwarding is enabled. If R_W=1 and RA==WA, Q captures r' rather than the old register value. The same applies to Qa when Ea=1 and RB==WA.
- REG_BANK_BYPASS_EN undefined: no forwarding. Q and Qa capture the pre-write value. The bank is a pure registered-read array.

## Test plan
- Reset: load 0xBEEF to reg 2, then assert CLR between clock edges -> Q, Qa, Z and C are 0 immediately. A read of reg 2 then returns 0x0000.
- Load/read: write 0x1234 to reg 5 (OP=00), then RA=5, RB=5, Ea=1 -> Q = Qa = 0x1234 one cycle later, Z=0, C=0.
- Wrap: load 0xFFFF to reg 1, then OP=01 -> reg 1 = 0x0000, Z=1, C=1. Then OP=10 -> reg 1 = 0xFFFF, Z=0, C=1.
- Ea gating: Qa = 0x00AA from reg 3 with Ea=1, then Ea=0 while reg 3 is rewritten to 0x0055 -> Qa stays 0x00AA. It shows 0x0055 on the first edge with Ea=1.
- Read-during-write: R_W=1, OP=00, WA=RA=4, D=0x0F0F, old value 0x1111 -> Q = 0x1111 without the macro, 0x0F0F with REG_BANK_BYPASS_EN.
- Isolation: eight sequential writes of distinct values to regs 0–7, then one OP=11 to reg 6 -> only reg 6 reads 0. All others keep their values. Z=1.
